// File: rtl/inst_ram_arbiter_pkg.sv
// Shared encodings for the instruction RAM arbiter: response owners,
// the {pend_valid, hold_valid} state view, and the starvation limit default.
package inst_ram_arbiter_pkg;

  // Owner of a read whose data returns next cycle
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_AUX   = 1'b1;

  // State view = {pend_valid, hold_valid}
  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_HOLD      = 2'b01;
  localparam logic [1:0] ST_RESP      = 2'b10;
  localparam logic [1:0] ST_RESP_HOLD = 2'b11;

  // Default number of consecutive aux denials before aux is forced through
  localparam int MAX_WAIT_DEFAULT = 4;

  // Wait counter width; MAX_WAIT is limited to 1..15
  localparam int WAIT_W = 4;

  // Saturating increment of the starvation counter
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] value,
                                                input logic [WAIT_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/inst_rsp_hold.sv
// One-entry parking register for a fetch response the consumer could not
// accept. Captures the live RAM word, keeps presenting it until the consumer
// takes it or a redirect cancels it, and muxes parked vs. live data.
module inst_rsp_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              live_valid,
  input  logic [DATA_W-1:0] live_data,
  input  logic              ready,
  input  logic              cancel,
  output logic              hold_valid,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  logic              capture;
  logic [DATA_W-1:0] hold_data;

  // A live response that is not accepted this cycle gets parked
  assign capture = live_valid & ~ready & ~hold_valid;

  // Parked entry is released by acceptance or by a redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (hold_valid && (ready || cancel)) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
    end
  end

  // Data payload only needs loading; hold_valid qualifies it
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_data <= live_data;
    end
  end

  // Parked data takes priority over whatever the RAM is returning now
  always_comb begin
    rsp_valid = live_valid;
    rsp_data  = live_data;
    if (hold_valid) begin
      rsp_valid = ~cancel;
      rsp_data  = hold_data;
    end
  end

endmodule

// File: rtl/inst_ram_arbiter.sv
// Arbitrates the single-port instruction RAM between the fetch stage and an
// auxiliary (boot/debug) port. Fetch normally wins; aux is forced through
// after MAX_WAIT consecutive denials. Read data returns one cycle after the
// grant and is steered to its owner; fetch data can be parked while the
// consumer stalls and is dropped on a redirect.
module inst_ram_arbiter
  import inst_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  input  logic              f_cancel,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  input  logic              f_rsp_ready,
  input  logic              a_req,
  input  logic [3:0]        a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_data,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_w_en,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  logic              pend_valid;
  logic              pend_owner;
  logic              pend_kill;
  logic              hold_valid;
  logic [WAIT_W-1:0] wait_cnt;

  logic              pend_is_fetch;
  logic              pend_is_aux;
  logic              aux_force;
  logic              fetch_ok;
  logic              read_issue;
  logic              live_valid;

  assign pend_is_fetch = pend_valid & (pend_owner == OWNER_FETCH);
  assign pend_is_aux   = pend_valid & (pend_owner == OWNER_AUX);

  // Grant: fetch first unless it is blocked by its own undelivered data or
  // aux has been starved long enough. Grants are held off during reset.
  always_comb begin
    aux_force = a_req & (wait_cnt == WAIT_LIM);
    fetch_ok  = f_req & ~hold_valid & ~(pend_is_fetch & ~f_rsp_ready);
    f_gnt     = fetch_ok & ~aux_force & ~reset;
    a_gnt     = a_req & ~f_gnt & ~reset;
  end

  // RAM port: the granted requester's address; only aux may write
  always_comb begin
    ram_en     = f_gnt | a_gnt;
    ram_addr   = a_gnt ? a_addr : f_addr;
    ram_w_en   = a_gnt ? a_we : 4'b0000;
    ram_w_data = a_wdata;
  end

  // Aux writes finish at the grant; only reads produce a return next cycle
  assign read_issue = f_gnt | (a_gnt & (a_we == 4'b0000));

  // Track whose read data the RAM will present next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_owner <= OWNER_FETCH;
      pend_kill  <= 1'b0;
    end else begin
      pend_valid <= read_issue;
      pend_owner <= f_gnt ? OWNER_FETCH : OWNER_AUX;
      // A cancel without a redirect fetch: nothing issued now may reach fetch
      pend_kill  <= f_cancel & ~f_gnt;
    end
  end

  // Count consecutive aux denials, saturating at the forcing threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (a_req && !a_gnt) begin
      wait_cnt <= sat_inc(wait_cnt, WAIT_LIM);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Live fetch return, suppressed by a cancel in the return cycle
  assign live_valid = pend_is_fetch & ~pend_kill & ~f_cancel;

  inst_rsp_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .live_valid (live_valid),
    .live_data  (ram_r_data),
    .ready      (f_rsp_ready),
    .cancel     (f_cancel),
    .hold_valid (hold_valid),
    .rsp_valid  (f_rsp_valid),
    .rsp_data   (f_rsp_data)
  );

  // Aux is always ready, so its read data is passed straight through
  assign a_rsp_valid = pend_is_aux;
  assign a_rsp_data  = ram_r_data;

endmodule

// File: tb/tb_inst_ram_arbiter.sv
// Bench for inst_ram_arbiter: a behavioural synchronous RAM, a reference
// model that tracks expected grants and return data from a shadow copy of
// memory, directed scenarios and a randomized phase.
module tb_inst_ram_arbiter;

  localparam int MAX_WAIT = 4;
  localparam logic [31:0] BASE = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_cancel, f_rsp_ready;
  logic [31:0] f_addr;
  logic        f_gnt, f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        a_req;
  logic [3:0]  a_we;
  logic [31:0] a_addr, a_wdata;
  logic        a_gnt, a_rsp_valid;
  logic [31:0] a_rsp_data;
  logic        ram_en;
  logic [31:0] ram_addr;
  logic [3:0]  ram_w_en;
  logic [31:0] ram_w_data;
  logic [31:0] ram_r_data;

  int n_checks = 0;
  int n_errors = 0;

  inst_ram_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_cancel    (f_cancel),
    .f_rsp_valid (f_rsp_valid),
    .f_rsp_data  (f_rsp_data),
    .f_rsp_ready (f_rsp_ready),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .ram_en      (ram_en),
    .ram_addr    (ram_addr),
    .ram_w_en    (ram_w_en),
    .ram_w_data  (ram_w_data),
    .ram_r_data  (ram_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // Behavioural RAM: 256 words, synchronous read, byte writes
  logic [31:0] mem [256];
  logic        init_req = 1'b0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (ram_en) begin
      if (ram_w_en != 4'b0000) mem[ram_addr[9:2]] <= merge(mem[ram_addr[9:2]], ram_w_data, ram_w_en);
      ram_r_data <= mem[ram_addr[9:2]];
    end
  end

  // Reference model: shadow memory, one outstanding return, one parked word
  logic [31:0] sm [256];
  bit          m_pend_v, m_pend_aux, m_hold_v;
  logic [31:0] m_pend_d, m_hold_d;
  int          m_wait;
  bit          e_fg, e_ag, e_frv, e_arv;
  logic [31:0] e_fdata;

  function automatic logic [31:0] word_addr(input int idx);
    return BASE | (32'(idx & 255) << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend_v = 0; m_pend_aux = 0; m_hold_v = 0; m_wait = 0;
    m_pend_d = '0; m_hold_d = '0;
  endtask

  // Sample on the falling edge: derive expectations from the model and compare
  task automatic at_neg(input string tag);
    bit force_a, blocked;
    @(negedge clk);
    force_a = a_req && (m_wait >= MAX_WAIT);
    blocked = m_hold_v || (m_pend_v && !m_pend_aux && !f_rsp_ready);
    e_fg    = f_req && !blocked && !force_a;
    e_ag    = a_req && !e_fg;
    e_frv   = m_hold_v ? !f_cancel : (m_pend_v && !m_pend_aux && !f_cancel);
    e_fdata = m_hold_v ? m_hold_d : m_pend_d;
    e_arv   = m_pend_v && m_pend_aux;
    chk({tag, ".f_gnt"}, 32'(f_gnt), 32'(e_fg));
    chk({tag, ".a_gnt"}, 32'(a_gnt), 32'(e_ag));
    chk({tag, ".ram_en"}, 32'(ram_en), 32'(e_fg || e_ag));
    chk({tag, ".ram_w_en"}, 32'(ram_w_en), e_ag ? 32'(a_we) : 32'd0);
    if (e_fg || e_ag) chk({tag, ".ram_addr"}, ram_addr, e_ag ? a_addr : f_addr);
    if (e_ag && a_we != 4'b0000) chk({tag, ".ram_w_data"}, ram_w_data, a_wdata);
    chk({tag, ".f_rsp_valid"}, 32'(f_rsp_valid), 32'(e_frv));
    if (e_frv) chk({tag, ".f_rsp_data"}, f_rsp_data, e_fdata);
    chk({tag, ".a_rsp_valid"}, 32'(a_rsp_valid), 32'(e_arv));
    if (e_arv) chk({tag, ".a_rsp_data"}, a_rsp_data, m_pend_d);
  endtask

  // Advance the model across the rising edge with the inputs of this cycle
  task automatic at_pos();
    @(posedge clk);
    if (e_fg)      $display("t=%0t fetch read  addr=%h", $time, f_addr);
    else if (e_ag) $display("t=%0t aux   %s addr=%h", $time, (a_we != 0) ? "write" : "read ", a_addr);
    if (m_hold_v) begin
      if (f_rsp_ready || f_cancel) m_hold_v = 0;
    end else if (e_frv && !f_rsp_ready) begin
      m_hold_v = 1; m_hold_d = e_fdata;
    end
    if (e_fg) begin
      m_pend_v = 1; m_pend_aux = 0; m_pend_d = sm[f_addr[9:2]];
    end else if (e_ag && a_we == 4'b0000) begin
      m_pend_v = 1; m_pend_aux = 1; m_pend_d = sm[a_addr[9:2]];
    end else begin
      m_pend_v = 0;
    end
    if (e_ag && a_we != 4'b0000) sm[a_addr[9:2]] = merge(sm[a_addr[9:2]], a_wdata, a_we);
    m_wait = (a_req && !e_ag) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = BASE; f_cancel = 0; f_rsp_ready = 1;
    a_req = 0; a_we = 4'b0000; a_addr = BASE; a_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 256; i++) sm[i] = 32'(i);
    model_reset();

    // Reset: grants and RAM enable stay low even with both requests up
    reset = 1; init_req = 1;
    f_req = 1; a_req = 1; a_we = 4'hf;
    #1;
    chk("rst.f_gnt", 32'(f_gnt), 0);
    chk("rst.a_gnt", 32'(a_gnt), 0);
    chk("rst.ram_en", 32'(ram_en), 0);
    chk("rst.ram_w_en", 32'(ram_w_en), 0);
    chk("rst.f_rsp_valid", 32'(f_rsp_valid), 0);
    chk("rst.a_rsp_valid", 32'(a_rsp_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    init_req = 0; idle_inputs(); reset = 0;

    // Back-to-back fetches return words 0, 1, 2
    for (int i = 0; i < 4; i++) begin
      f_req = (i < 3); f_addr = BASE + 32'(4 * i);
      at_neg($sformatf("seq%0d", i));
      if (i < 3) chk($sformatf("seq%0d.gnt", i), 32'(f_gnt), 1);
      if (i > 0) chk($sformatf("seq%0d.data", i), f_rsp_data, 32'(i - 1));
      at_pos();
    end

    // Contention: fetch wins 4 cycles, aux forced on the 5th, fetch resumes
    f_req = 1; f_addr = word_addr(40); a_req = 1; a_we = 0; a_addr = word_addr(128);
    for (int k = 0; k < 6; k++) begin
      at_neg($sformatf("arb%0d", k));
      chk($sformatf("arb%0d.f_gnt", k), 32'(f_gnt), 32'(k != 4));
      chk($sformatf("arb%0d.a_gnt", k), 32'(a_gnt), 32'(k == 4));
      at_pos();
    end
    idle_inputs(); at_neg("arb_drain"); at_pos();

    // Stall: fetch word 8 parked for 3 cycles while aux reads word 64
    f_req = 1; f_addr = word_addr(8);
    at_neg("hold_g"); at_pos();
    f_rsp_ready = 0;
    at_neg("hold1"); chk("hold1.f_gnt", 32'(f_gnt), 0); chk("hold1.data", f_rsp_data, 8); at_pos();
    a_req = 1; a_addr = BASE + 32'h100;
    at_neg("hold2"); chk("hold2.a_gnt", 32'(a_gnt), 1); chk("hold2.data", f_rsp_data, 8); at_pos();
    a_req = 0;
    at_neg("hold3");
    chk("hold3.a_rsp_valid", 32'(a_rsp_valid), 1); chk("hold3.a_data", a_rsp_data, 64);
    chk("hold3.data", f_rsp_data, 8); chk("hold3.f_gnt", 32'(f_gnt), 0);
    at_pos();
    f_rsp_ready = 1;
    at_neg("hold4"); chk("hold4.valid", 32'(f_rsp_valid), 1); chk("hold4.data", f_rsp_data, 8); at_pos();
    at_neg("hold5"); chk("hold5.f_gnt", 32'(f_gnt), 1); at_pos();
    idle_inputs(); at_neg("hold_drain"); at_pos();

    // Redirect: old response suppressed, redirect target delivered
    f_req = 1; f_addr = word_addr(32);
    at_neg("cxl_g"); at_pos();
    f_cancel = 1; f_addr = BASE + 32'h40;
    at_neg("cxl1"); chk("cxl1.valid", 32'(f_rsp_valid), 0); chk("cxl1.f_gnt", 32'(f_gnt), 1); at_pos();
    idle_inputs();
    at_neg("cxl2"); chk("cxl2.valid", 32'(f_rsp_valid), 1); chk("cxl2.data", f_rsp_data, 16); at_pos();

    // Aux write then fetch of the same word
    a_req = 1; a_we = 4'b1111; a_addr = BASE + 32'h10; a_wdata = 32'hdeadbeef;
    at_neg("wr0"); chk("wr0.a_gnt", 32'(a_gnt), 1); at_pos();
    idle_inputs(); f_req = 1; f_addr = BASE + 32'h10;
    at_neg("wr1"); chk("wr1.a_rsp_valid", 32'(a_rsp_valid), 0); at_pos();
    idle_inputs();
    at_neg("wr2"); chk("wr2.data", f_rsp_data, 32'hdeadbeef); at_pos();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      f_req       = ($urandom_range(0, 9) < 7);
      f_addr      = word_addr(int'($urandom_range(0, 255)));
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      f_cancel    = ($urandom_range(0, 11) == 0);
      a_req       = ($urandom_range(0, 2) == 0);
      a_we        = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      a_addr      = word_addr(int'($urandom_range(0, 255)));
      a_wdata     = $urandom;
      at_neg($sformatf("rnd%0d", c));
      at_pos();
    end
    idle_inputs();
    at_neg("rnd_drain0"); at_pos();
    at_neg("rnd_drain1"); at_pos();

    // Asynchronous reset while a fetch word is parked
    f_req = 1; f_addr = word_addr(5);
    at_neg("rh_g"); at_pos();
    f_rsp_ready = 0;
    at_neg("rh_cap"); at_pos();
    a_req = 1; a_we = 4'hf; f_req = 1;
    #1 chk("rh.pre_valid", 32'(f_rsp_valid), 1);
    #1 reset = 1;
    #1;
    chk("rh.f_gnt", 32'(f_gnt), 0);
    chk("rh.a_gnt", 32'(a_gnt), 0);
    chk("rh.f_rsp_valid", 32'(f_rsp_valid), 0);
    chk("rh.a_rsp_valid", 32'(a_rsp_valid), 0);
    chk("rh.ram_en", 32'(ram_en), 0);
    chk("rh.ram_w_en", 32'(ram_w_en), 0);
    @(posedge clk); @(posedge clk); #1;
    idle_inputs(); reset = 0; model_reset();
    for (int k = 0; k < 2; k++) begin
      at_neg($sformatf("rh_after%0d", k));
      chk($sformatf("rh_after%0d.valid", k), 32'(f_rsp_valid), 0);
      at_pos();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
